// File: rtl/tile_state_ctrl_pkg.sv
// Shared encodings for the Minesweeper tile-state controller.
package tile_state_ctrl_pkg;

    // Game FSM encodings; kept as plain 2-bit constants so legacy consumers
    // (renderer, status LEDs) can compare against raw values.
    localparam logic [1:0] GAME_IDLE    = 2'd0;
    localparam logic [1:0] GAME_PLAYING = 2'd1;
    localparam logic [1:0] GAME_WON     = 2'd2;
    localparam logic [1:0] GAME_LOST    = 2'd3;

    typedef logic [1:0] game_state_t;

endpackage

// File: rtl/tile_state_ctrl_if.sv
// Board bus between input decode / flood-fill (master) and the tile-state
// controller (slave). The renderer taps the state outputs from the same bus.
interface tile_state_ctrl_if #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
);
    localparam int TOTAL_TILES = GRID_W * GRID_H;
    localparam int INDEX_BITS  = $clog2(TOTAL_TILES);
    localparam int CNT_BITS    = $clog2(TOTAL_TILES + 1);

    // Requests toward the controller
    logic                   new_game;
    logic [INDEX_BITS-1:0]  tile_index;
    logic                   flag;
    logic                   reveal;
    logic [TOTAL_TILES-1:0] flood_update;
    logic                   flood_apply;
    logic [TOTAL_TILES-1:0] mine_map;

    // Board state from the controller
    logic [TOTAL_TILES-1:0] flagged;
    logic [TOTAL_TILES-1:0] revealed;
    logic [CNT_BITS-1:0]    flags_used;
    logic [CNT_BITS-1:0]    safe_revealed;
    logic [1:0]             game_state;

    modport master (
        output new_game, tile_index, flag, reveal, flood_update, flood_apply, mine_map,
        input  flagged, revealed, flags_used, safe_revealed, game_state
    );

    modport slave (
        input  new_game, tile_index, flag, reveal, flood_update, flood_apply, mine_map,
        output flagged, revealed, flags_used, safe_revealed, game_state
    );

endinterface

// File: rtl/tile_state_ctrl_popcount.sv
// Combinational population count; used to count newly revealed safe tiles.
module popcount #(
    parameter int WIDTH = 64,
    parameter int OUT_W = 7
) (
    input  logic [WIDTH-1:0] bits,
    output logic [OUT_W-1:0] count
);

    // Sum every input bit into the count
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // otherwise an unassigned path infers a latch.
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/tile_state_ctrl.sv
// Per-tile flag/reveal store and game-status FSM for the Minesweeper board.
// Applies cursor flag/reveal edges and flood-fill masks, keeps flag and
// safe-reveal counts, and tracks IDLE/PLAYING/WON/LOST.
module tile_state_ctrl
    import tile_state_ctrl_pkg::*;
#(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int NUM_MINES = 10
) (
    input logic              clk,
    input logic              rst,
    tile_state_ctrl_if.slave bus
);

    localparam int TOTAL_TILES = GRID_W * GRID_H;
    localparam int INDEX_BITS  = $clog2(TOTAL_TILES);
    localparam int CNT_BITS    = $clog2(TOTAL_TILES + 1);
    localparam int SAFE_TILES  = TOTAL_TILES - NUM_MINES;

    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] FLAG_MAX  = CNT_BITS'(NUM_MINES);
    localparam logic [CNT_BITS-1:0] SAFE_MAX  = CNT_BITS'(SAFE_TILES);
    localparam logic [CNT_BITS:0]   SAFE_WIDE = (CNT_BITS + 1)'(SAFE_TILES);
    localparam logic [INDEX_BITS:0] IDX_LIMIT = (INDEX_BITS + 1)'(TOTAL_TILES);

    // Registered state
    logic [TOTAL_TILES-1:0] flagged_q, revealed_q;
    logic [CNT_BITS-1:0]    flags_used_q, safe_q;
    game_state_t            state_q;
    logic                   flag_q, reveal_q;

    // Next-state values
    logic [TOTAL_TILES-1:0] flagged_d, revealed_d, reveal_mask, new_safe_bits;
    logic [CNT_BITS-1:0]    flags_used_d, safe_d, new_safe;
    logic [CNT_BITS:0]      safe_sum;
    game_state_t            state_d;
    logic                   mine_hit;

    logic                   flag_edge, reveal_edge, idx_ok, playing;
    logic [INDEX_BITS-1:0]  idx;

    assign idx         = bus.tile_index;
    assign idx_ok      = {1'b0, idx} < IDX_LIMIT;
    assign flag_edge   = bus.flag & ~flag_q;
    assign reveal_edge = bus.reveal & ~reveal_q;
    assign playing     = (state_q == GAME_PLAYING) && !bus.new_game;

    // Tile vectors and flag count: cursor reveal beats cursor flag; flood ORs in
    always_comb begin
        flagged_d    = flagged_q;
        flags_used_d = flags_used_q;
        reveal_mask  = '0;
        mine_hit     = 1'b0;

        if (bus.new_game) begin
            flagged_d    = '0;
            flags_used_d = '0;
        end else if (playing) begin
            if (reveal_edge && idx_ok) begin
                // A concurrent flag edge is dropped even if the reveal is a no-op.
                if (!flagged_q[idx] && !revealed_q[idx]) begin
                    reveal_mask[idx] = 1'b1;
                    if (bus.mine_map[idx]) begin
                        mine_hit    = 1'b1;
                        reveal_mask = reveal_mask | bus.mine_map;
                    end
                end
            end else if (flag_edge && idx_ok && !revealed_q[idx]) begin
                if (flagged_q[idx]) begin
                    flagged_d[idx] = 1'b0;
                    flags_used_d   = flags_used_q - CNT_ONE;
                end else if (flags_used_q < FLAG_MAX) begin
                    flagged_d[idx] = 1'b1;
                    flags_used_d   = flags_used_q + CNT_ONE;
                end
            end

            // Flood never uncovers mines or flagged tiles.
            if (bus.flood_apply) begin
                reveal_mask = reveal_mask | (bus.flood_update & ~flagged_d & ~bus.mine_map);
            end
        end

        revealed_d    = bus.new_game ? '0 : (revealed_q | reveal_mask);
        new_safe_bits = revealed_d & ~revealed_q & ~bus.mine_map;
    end

    popcount #(
        .WIDTH (TOTAL_TILES),
        .OUT_W (CNT_BITS)
    ) u_popcount (
        .bits  (new_safe_bits),
        .count (new_safe)
    );

    // Safe-reveal count (saturating) and game FSM; a mine hit outranks a win
    always_comb begin
        safe_sum = {1'b0, safe_q} + {1'b0, new_safe};
        safe_d   = safe_q;
        state_d  = state_q;

        if (bus.new_game) begin
            safe_d  = '0;
            state_d = GAME_PLAYING;
        end else if (playing) begin
            safe_d = (safe_sum >= SAFE_WIDE) ? SAFE_MAX : safe_sum[CNT_BITS-1:0];
            if (mine_hit) begin
                state_d = GAME_LOST;
            end else if (safe_d == SAFE_MAX) begin
                state_d = GAME_WON;
            end
        end
    end

    // Board registers, counters, FSM and edge-detect history
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst) begin
            flagged_q    <= '0;
            revealed_q   <= '0;
            flags_used_q <= '0;
            safe_q       <= '0;
            state_q      <= GAME_IDLE;
            flag_q       <= 1'b0;
            reveal_q     <= 1'b0;
        end else begin
            flagged_q    <= flagged_d;
            revealed_q   <= revealed_d;
            flags_used_q <= flags_used_d;
            safe_q       <= safe_d;
            state_q      <= state_d;
            flag_q       <= bus.flag;
            reveal_q     <= bus.reveal;
        end
    end

    assign bus.flagged       = flagged_q;
    assign bus.revealed      = revealed_q;
    assign bus.flags_used    = flags_used_q;
    assign bus.safe_revealed = safe_q;
    assign bus.game_state    = state_q;

endmodule
